// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - fetch/data arbiter for one shared single-port BRAM
// DM wins conflicts unless IF has lost STARVE_MAX consecutive times; responses are tagged one cycle later.
module imem_dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = 12,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_stall,
   output logic                  if_valid,
   output logic [31:0]           if_rdata,
   input  logic                  dm_req,
   input  logic [3:0]            dm_we,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [31:0]           dm_wdata,
   output logic                  dm_stall,
   output logic                  dm_valid,
   output logic [31:0]           dm_rdata,
   output logic                  dm_err,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_IF     = 2'd1,
      TAG_DM     = 2'd2,
      TAG_DM_ERR = 2'd3
   } tag_t;

   tag_t       tag_q, tag_d;
   logic [3:0] starve_q, starve_d;
   logic       grant_if, grant_dm, dm_oor;
   logic       unused;

   // IF word address bits above the memory depth are deliberately ignored (wrap)
   assign unused = ^{if_addr[ADDR_W-1:DEPTH_LOG2+2], if_addr[1:0], dm_addr[1:0]};

   assign dm_oor   = |dm_addr[ADDR_W-1:DEPTH_LOG2+2];
   assign grant_if = if_req & (~dm_req | (starve_q == STARVE_LIM));
   assign grant_dm = dm_req & ~grant_if;

   assign if_stall = rst_n & if_req & ~grant_if;
   assign dm_stall = rst_n & dm_req & ~grant_dm;

   assign mem_en    = rst_n & (grant_if | (grant_dm & ~dm_oor));
   assign mem_we    = (rst_n & grant_dm & ~dm_oor) ? dm_we : 4'h0;
   assign mem_addr  = grant_if ? if_addr[DEPTH_LOG2+1:2] : dm_addr[DEPTH_LOG2+1:2];
   assign mem_wdata = grant_dm ? dm_wdata : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q    <= TAG_NONE;
         starve_q <= 4'd0;
      end else begin
         tag_q    <= tag_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      tag_d    = TAG_NONE;
      starve_d = starve_q;
      if (grant_if)
         tag_d = TAG_IF;
      else if (grant_dm)
         tag_d = dm_oor ? TAG_DM_ERR : TAG_DM;

      if (!if_req || grant_if)
         starve_d = 4'd0;
      else if (starve_q != STARVE_LIM)
         starve_d = starve_q + 4'd1;
   end

   assign if_valid = (tag_q == TAG_IF);
   assign if_rdata = (tag_q == TAG_IF) ? mem_rdata : 32'h0;
   assign dm_valid = (tag_q == TAG_DM) || (tag_q == TAG_DM_ERR);
   assign dm_err   = (tag_q == TAG_DM_ERR);
   assign dm_rdata = (tag_q == TAG_DM) ? mem_rdata : 32'h0;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous BRAM (unified instruction/data memory) between the pipeline's fetch stage (IF) and memory stage (DM).
- Resolves conflicts by priority: DM wins by default, with an anti-starvation counter that guarantees fetch forward progress.
- Issues per-requester stall signals to the hazard logic and returns read data one cycle later with an owner-tagged valid.
- Sits between the core pipeline and the memory macro inside top.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (4096 words).
- STARVE_MAX, 4, number of consecutive IF losses after which IF wins the next conflict; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address (word aligned)
- if_stall  out  1  fetch request not granted this cycle
- if_valid  out  1  fetch data valid (response cycle)
- if_rdata  out  32  fetch read data
- dm_req  in  1  data request (read or write)
- dm_we  in  4  byte write enables; 0 means read
- dm_addr  in  ADDR_W  data byte address (word aligned)
- dm_wdata  in  32  write data
- dm_stall  out  1  data request not granted this cycle
- dm_valid  out  1  data access complete (response cycle)
- dm_rdata  out  32  data read data
- dm_err  out  1  address out of range; qualifies dm_valid
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  DEPTH_LOG2  BRAM word address, addr[DEPTH_LOG2+1:2]
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, 1-cycle latency

Behaviour:
- Reset (async, rst_n=0): if_valid=0, dm_valid=0, dm_err=0, starve_cnt=0, owner tag=NONE. mem_en=0 and mem_we=0 are forced while rst_n is low. Stalls are combinational from req/grant; both read 0 while in reset.
- Grant, cycle N, combinational:
  - Only one requester: that requester is granted.
  - Both requesting: IF is granted if starve_cnt==STARVE_MAX, otherwise DM is granted.
- Stall: x_stall = x_req & ~grant_x. A stalled requester holds its request and operands stable; the arbiter does not latch them.
- Memory drive: the granted port drives mem_addr, mem_we (IF always 0), and mem_wdata, with mem_en=1. With no grant, mem_en=0 and mem_we=0.
- Range check: if any dm_addr bit at or above DEPTH_LOG2+2 is set, DM is still granted per the priority rule, but mem_en=0 and mem_we=0. The response in N+1 is dm_valid=1, dm_err=1, dm_rdata=0. IF addresses are not range-checked; they wrap modulo depth.
- Owner tag register: loaded at each edge with {IF, DM, DM_ERR, NONE} from the cycle-N grant.
- Response, cycle N+1:
  - Tag IF: if_valid=1 and if_rdata=mem_rdata.
  - Tag DM: dm_valid=1 and dm_rdata=mem_rdata. For writes, dm_rdata is don't-care.
  - Other outputs: the non-owner valid is 0, and that port's rdata is 0.
  - Latency is exactly 1 cycle from grant to valid. Back-to-back grants give a throughput of one access per cycle.
- starve_cnt, 4 bits, updated at each edge:
  - Reset to 0 when IF is granted or if_req=0.
  - Incremented when IF is stalled, saturating at STARVE_MAX.
- Reset mid-operation: an outstanding response is dropped (valid goes low immediately), and no write is issued after rst_n falls.

Test Plan:
- IF only: if_req=1, if_addr=0x10, mem word 4 = 0x00500093 -> mem_addr=4, mem_en=1, if_stall=0; next cycle if_valid=1, if_rdata=0x00500093.
- DM write then read: dm_we=0xF, addr 0x20, wdata 0xDEADBEEF; next cycle dm_we=0, addr 0x20 -> mem_we=0xF then 0; dm_valid on both response cycles; read returns 0xDEADBEEF.
- Byte write: dm_we=0x2 at 0x20, wdata 0x0000AB00 -> subsequent read returns 0xDEADABEF.
- Conflict and starvation (STARVE_MAX=4): both requesting continuously -> DM granted cycles 0-3 (if_stall=1), IF granted cycle 4 (dm_stall=1), starve_cnt back to 0, DM granted cycle 5.
- Out of range: dm_req=1, dm_addr=0x4000 (DEPTH_LOG2=12) -> mem_en=0; next cycle dm_valid=1, dm_err=1, dm_rdata=0.
- Async reset mid-access: grant DM write at cycle N, assert rst_n=0 mid-cycle -> mem_we=0 and mem_en=0 immediately; dm_valid=0 and starve_cnt=0 after release.
